// File: rtl/swc_fbm_shadow_reader.sv
// swc_fbm_shadow_reader: multi-port page buffer with a page-chained, word-unpacking readout.
module swc_fbm_shadow_reader #(
    parameter int g_num_pages  = 64,
    parameter int g_page_size  = 64,
    parameter int g_ratio      = 2,
    parameter int g_data_width = 16,
    parameter int g_num_wports = 2,
    localparam int LPP = g_page_size / g_ratio,
    localparam int PW  = $clog2(g_num_pages),
    localparam int AW  = PW + $clog2(LPP),
    localparam int LW  = g_data_width * g_ratio
) (
    input  logic                         clk_core_i,
    input  logic                         rst_i,
    input  logic [g_num_wports-1:0]      wr_we_i,
    input  logic [g_num_wports*AW-1:0]   wr_addr_i,
    input  logic [g_num_wports*LW-1:0]   wr_data_i,
    input  logic                         rd_start_i,
    input  logic [15:0]                  rd_size_i,
    input  logic [PW-1:0]                rd_page_i,
    input  logic                         rd_page_valid_i,
    output logic                         rd_page_ready_o,
    output logic [g_data_width-1:0]      dout_o,
    output logic                         dout_valid_o,
    input  logic                         dout_ready_i,
    output logic                         dout_last_o,
    output logic                         rd_busy_o,
    output logic                         rd_error_o
);
    localparam int LCW   = LPP > 1 ? $clog2(LPP) : 1;
    localparam int NW    = g_ratio > 1 ? $clog2(g_ratio) : 1;
    localparam int DEPTH = g_num_pages * LPP;

    typedef enum logic [1:0] {IDLE, WAIT_PAGE, FETCH, STREAM} state_e;

    logic [LW-1:0]           mem_q [DEPTH];
    state_e                  state_q;
    logic [15:0]             rem_q;
    logic [PW-1:0]           page_q;
    logic [LCW-1:0]          line_q;
    logic [NW-1:0]           lane_q;
    logic [LW-1:0]           buf_q;
    logic [g_data_width-1:0] dout_q;
    logic                    valid_q, last_q, pready_q, busy_q, err_q;
    logic [AW-1:0]           raddr;

    assign raddr           = AW'(int'(page_q) * LPP + int'(line_q));
    assign rd_page_ready_o = pready_q;
    assign dout_o          = dout_q;
    assign dout_valid_o    = valid_q;
    assign dout_last_o     = last_q;
    assign rd_busy_o       = busy_q;
    assign rd_error_o      = err_q;

    // Descending loop so the lowest-index port's assignment lands last and wins.
    always_ff @(posedge clk_core_i) begin
        for (int k = g_num_wports - 1; k >= 0; k--)
            if (wr_we_i[k]) mem_q[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*LW +: LW];
    end

    always_ff @(posedge clk_core_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            page_q   <= '0;
            line_q   <= '0;
            lane_q   <= '0;
            buf_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            pready_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= rd_start_i && (state_q != IDLE || rd_size_i == 16'd0);
            case (state_q)
                IDLE: begin
                    if (rd_start_i && rd_size_i != 16'd0) begin
                        rem_q    <= rd_size_i;
                        state_q  <= WAIT_PAGE;
                        pready_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                WAIT_PAGE: begin
                    if (rd_page_valid_i) begin
                        page_q   <= rd_page_i;
                        line_q   <= '0;
                        state_q  <= FETCH;
                        pready_q <= 1'b0;
                    end
                end
                FETCH: begin
                    buf_q   <= mem_q[raddr];
                    dout_q  <= mem_q[raddr][g_data_width-1:0];
                    lane_q  <= '0;
                    state_q <= STREAM;
                    valid_q <= 1'b1;
                    last_q  <= rem_q == 16'd1;
                end
                default: begin
                    if (dout_ready_i) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (lane_q == NW'(g_ratio - 1)) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (line_q == LCW'(LPP - 1)) begin
                                state_q  <= WAIT_PAGE;
                                pready_q <= 1'b1;
                            end else begin
                                line_q  <= line_q + 1'b1;
                                state_q <= FETCH;
                            end
                        end else begin
                            lane_q <= lane_q + 1'b1;
                            dout_q <= buf_q[(int'(lane_q) + 1) * g_data_width +: g_data_width];
                            last_q <= rem_q == 16'd2;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_swc_fbm_shadow_reader.sv
// tb_swc_fbm_shadow_reader: randomized readouts checked against a word-indexed page model.
module tb_swc_fbm_shadow_reader;
    logic        clk = 0;
    logic        rst_i = 1;
    logic [1:0]  wr_we_i = 0;
    logic [7:0]  wr_addr_i = 0;
    logic [63:0] wr_data_i = 0;
    logic        rd_start_i = 0;
    logic [15:0] rd_size_i = 0;
    logic [1:0]  rd_page_i = 0;
    logic        rd_page_valid_i = 0;
    logic        rd_page_ready_o;
    logic [15:0] dout_o;
    logic        dout_valid_o;
    logic        dout_ready_i = 0;
    logic        dout_last_o;
    logic        rd_busy_o;
    logic        rd_error_o;

    int total = 0, bad = 0;
    logic [31:0] mem_m [16];
    logic [1:0]  pl [4];

    swc_fbm_shadow_reader #(.g_num_pages(4), .g_page_size(8), .g_ratio(2),
                            .g_data_width(16), .g_num_wports(2)) dut (
        .clk_core_i(clk), .rst_i(rst_i), .wr_we_i(wr_we_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .rd_start_i(rd_start_i), .rd_size_i(rd_size_i),
        .rd_page_i(rd_page_i), .rd_page_valid_i(rd_page_valid_i),
        .rd_page_ready_o(rd_page_ready_o), .dout_o(dout_o), .dout_valid_o(dout_valid_o),
        .dout_ready_i(dout_ready_i), .dout_last_o(dout_last_o), .rd_busy_o(rd_busy_o),
        .rd_error_o(rd_error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] we, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
        wr_we_i = we;
        wr_addr_i = {a1, a0};
        wr_data_i = {d1, d0};
        if (we[1]) mem_m[a1] = d1;
        if (we[0]) mem_m[a0] = d0;
        tick();
        wr_we_i = 0;
    endtask

    task automatic run_read(input int size, input int stall, input bit poke);
        logic [15:0] exp_q[$];
        int np = (size + 7) / 8;
        int widx = 0, pidx = 0, cyc = 0, hs = -1, fv = -1, sleft = 0;
        bit sdone = 0, held = 0, bogus = 0, exp_err;
        logic [15:0] pd;
        logic pl_last;
        for (int i = 0; i < size; i++)
            exp_q.push_back(16'(mem_m[pl[i/8]*4 + (i%8)/2] >> (16 * (i % 2))));
        rd_start_i = 1;
        rd_size_i = 16'(size);
        tick();
        rd_start_i = 0;
        while (cyc < 400) begin
            if (widx == size) begin
                total++;
                if (rd_busy_o !== 0 || dout_valid_o !== 0 || rd_page_ready_o !== 0) begin
                    bad++;
                    $display("FAIL end_idle: busy=%b valid=%b pready=%b want 0 0 0", rd_busy_o, dout_valid_o, rd_page_ready_o);
                end
                break;
            end
            exp_err = bogus;
            bogus = 0;
            rd_start_i = 0;
            if (poke && cyc == 3) begin
                rd_start_i = 1;
                rd_size_i = 16'd5;
                bogus = 1;
            end
            if (stall == 2 && widx == 1 && !sdone) begin
                sleft = 3;
                sdone = 1;
            end
            dout_ready_i = stall == 1 ? ($urandom_range(0, 3) != 0) : (sleft == 0);
            if (sleft > 0) sleft--;
            rd_page_valid_i = pidx < np && (stall != 1 || $urandom_range(0, 1) == 1);
            rd_page_i = pl[pidx < 4 ? pidx : 0];
            total++;
            if (rd_error_o !== exp_err) begin
                bad++;
                $display("FAIL error_pulse: cyc=%0d got=%b want=%b", cyc, rd_error_o, exp_err);
            end
            total++;
            if ((dout_valid_o & rd_page_ready_o) !== 0) begin
                bad++;
                $display("FAIL exclusive: valid=%b pready=%b want not both", dout_valid_o, rd_page_ready_o);
            end
            if (rd_page_ready_o === 1) begin
                total++;
                if (pidx >= np) begin
                    bad++;
                    $display("FAIL extra_page: pages_taken=%0d want max %0d", pidx, np);
                end
            end
            if (held) begin
                total++;
                if (dout_o !== pd || dout_last_o !== pl_last) begin
                    bad++;
                    $display("FAIL hold: dout=%h last=%b want %h %b", dout_o, dout_last_o, pd, pl_last);
                end
            end
            if (dout_valid_o === 1) begin
                if (fv < 0) fv = cyc;
                if (dout_ready_i) begin
                    total++;
                    if (dout_o !== exp_q[widx] || dout_last_o !== (widx == size - 1)) begin
                        bad++;
                        $display("FAIL word%0d: dout=%h last=%b want %h %b", widx, dout_o, dout_last_o, exp_q[widx], widx == size - 1);
                    end
                    widx++;
                end
            end
            held = dout_valid_o === 1 && !dout_ready_i;
            pd = dout_o;
            pl_last = dout_last_o;
            if (rd_page_ready_o === 1 && rd_page_valid_i) begin
                pidx++;
                if (hs < 0) hs = cyc;
            end
            cyc++;
            tick();
        end
        rd_start_i = 0;
        rd_page_valid_i = 0;
        dout_ready_i = 0;
        total++;
        if (cyc >= 400 || pidx != np || fv - hs != 2) begin
            bad++;
            $display("FAIL read_sz%0d: cycles=%0d pages=%0d latency=%0d want <400 %0d 2", size, cyc, pidx, fv - hs, np);
        end
        if (exp_err || bogus) tick();
    endtask

    task automatic test_reset();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
        total++;
        if ({dout_valid_o, dout_last_o, rd_page_ready_o, rd_busy_o, rd_error_o} !== 5'b0 || dout_o !== 16'h0) begin
            bad++;
            $display("FAIL reset: v/l/pr/b/e=%b dout=%h want 00000 0000",
                     {dout_valid_o, dout_last_o, rd_page_ready_o, rd_busy_o, rd_error_o}, dout_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) wr(2'b01, 4'(i), 4'(15 - i), $urandom, 32'h0);
        for (int i = 0; i < 8; i++) wr(2'(($urandom_range(1, 3))), 4'($urandom), 4'($urandom), $urandom, $urandom);
    endtask

    task automatic test_basic();
        wr(2'b01, 4'd0, 4'd0, 32'h2222_1111, 32'h0);
        pl[0] = 0;
        run_read(2, 0, 0);
    endtask

    task automatic test_priority();
        wr(2'b11, 4'd5, 4'd5, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        pl[0] = 1;
        run_read(4, 0, 0);
    endtask

    task automatic test_multi_page();
        pl[0] = 2;
        pl[1] = 1;
        run_read(10, 0, 0);
    endtask

    task automatic test_partial();
        pl[0] = 3;
        run_read(3, 0, 0);
    endtask

    task automatic test_stall_and_busy_start();
        pl[0] = 1;
        run_read(6, 2, 1);
    endtask

    task automatic test_error_idle();
        rd_start_i = 1;
        rd_size_i = 0;
        tick();
        rd_start_i = 0;
        total++;
        if (rd_error_o !== 1 || rd_busy_o !== 0) begin
            bad++;
            $display("FAIL err_zero: err=%b busy=%b want 1 0", rd_error_o, rd_busy_o);
        end
        tick();
        total++;
        if (rd_error_o !== 0 || rd_busy_o !== 0) begin
            bad++;
            $display("FAIL err_single: err=%b busy=%b want 0 0", rd_error_o, rd_busy_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int sz = $urandom_range(1, 32);
            for (int i = 0; i < 4; i++) pl[i] = 2'($urandom);
            if (n % 3 == 0) wr(2'b11, 4'($urandom), 4'($urandom), $urandom, $urandom);
            run_read(sz, 1, sz >= 6 && n % 2 == 1);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        rd_start_i = 1;
        rd_size_i = 16'd8;
        rd_page_i = 0;
        rd_page_valid_i = 1;
        dout_ready_i = 0;
        tick();
        rd_start_i = 0;
        while (dout_valid_o !== 1 && c < 20) begin
            if (rd_page_ready_o === 1) begin
                tick();
                rd_page_valid_i = 0;
            end else tick();
            c++;
        end
        rd_page_valid_i = 0;
        rst_i = 1;
        tick();
        rst_i = 0;
        total++;
        if (c >= 20 || dout_valid_o !== 0 || rd_busy_o !== 0 || rd_page_ready_o !== 0) begin
            bad++;
            $display("FAIL reset_mid: wait=%0d valid=%b busy=%b pready=%b want <20 0 0 0", c, dout_valid_o, rd_busy_o, rd_page_ready_o);
        end
        pl[0] = 0;
        run_read(5, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_priority();
        test_multi_page();
        test_partial();
        test_stall_and_busy_start();
        test_error_idle();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/swc_fbm_shadow_reader.md
SWC_FBM_SHADOW_READER -- requirements
Module: swc_fbm_shadow_reader

Interface
REQ-001 SHALL have parameter g_num_pages, default 64, meaning number of pages in the buffer memory.
REQ-002 SHALL have parameter g_page_size, default 64, meaning data words per page (multiple of g_ratio).
REQ-003 SHALL have parameter g_ratio, default 2, meaning data words packed per memory line.
REQ-004 SHALL have parameter g_data_width, default 16, meaning width of one data word.
REQ-005 SHALL have parameter g_num_wports, default 2, meaning number of independent write ports.
REQ-006 SHALL derive these widths: LPP = g_page_size/g_ratio lines per page; AW = clog2(g_num_pages)+clog2(LPP); PW = clog2(g_num_pages); LW = g_data_width*g_ratio.
REQ-007 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-008 clk_core_i  in  1  core clock, all logic on rising edge.
REQ-009 rst_i  in  1  synchronous active-high reset.
REQ-010 wr_we_i  in  g_num_wports  per-port write enable.
REQ-011 wr_addr_i  in  g_num_wports*AW  per-port line address, port k at bits [k*AW +: AW].
REQ-012 wr_data_i  in  g_num_wports*LW  per-port line data, port k at bits [k*LW +: LW].
REQ-013 rd_start_i  in  1  start a readout.
REQ-014 rd_size_i  in  16  readout length in data words.
REQ-015 rd_page_i  in  PW  next page of the chain.
REQ-016 rd_page_valid_i  in  1  rd_page_i valid.
REQ-017 rd_page_ready_o  out  1  page accepted when valid and ready are both high.
REQ-018 dout_o  out  g_data_width  unpacked data word.
REQ-019 dout_valid_o  out  1  dout_o valid.
REQ-020 dout_ready_i  in  1  sink accepts the word.
REQ-021 dout_last_o  out  1  marks the final word of a readout.
REQ-022 rd_busy_o  out  1  readout in progress.
REQ-023 rd_error_o  out  1  one-cycle pulse on an illegal start.

Function
REQ-024 SHALL write each line wr_data_i to memory line wr_addr_i of every port with wr_we_i high, on the clock edge.
REQ-025 SHALL give the lowest-index port priority when several ports write the same address in one cycle.
REQ-026 SHALL register the memory read (1-cycle latency), with read-before-write: a same-cycle write to the line being read returns the old data.
REQ-027 SHALL use four FSM states: IDLE, WAIT_PAGE, FETCH, STREAM.
REQ-028 IDLE: rd_start_i=1 with rd_size_i!=0 latches remaining=rd_size_i and moves to WAIT_PAGE.
REQ-029 IDLE: rd_start_i=1 with rd_size_i=0 is ignored and pulses rd_error_o.
REQ-030 A rd_start_i in any state other than IDLE is ignored and pulses rd_error_o; the current readout continues.
REQ-031 WAIT_PAGE: rd_page_ready_o=1; on handshake, latch the page, set line=0, go to FETCH.
REQ-032 FETCH: read address = page*LPP+line; next state STREAM with lane=0.
REQ-033 First dout_valid_o SHALL occur 2 cycles after the page handshake.
REQ-034 STREAM: dout_valid_o=1; dout_o = line bits [lane*g_data_width +: g_data_width] (lane 0 = LSBs).
REQ-035 STREAM: dout_o and dout_last_o SHALL stay stable while dout_ready_i=0.
REQ-036 STREAM, on handshake: decrement remaining, then evaluate in this order:
  - remaining reaches 0 -> IDLE;
  - else lane=g_ratio-1 and line=LPP-1 -> WAIT_PAGE;
  - else lane=g_ratio-1 -> line+1, FETCH;
  - else lane+1, stay in STREAM.
REQ-037 dout_last_o SHALL be high exactly when remaining=1 in STREAM.
REQ-038 Remaining words of a partial final line or page SHALL be discarded; no further page SHALL be requested after the last word.
REQ-039 rd_busy_o SHALL be high in every state except IDLE.
REQ-040 rd_page_ready_o and dout_valid_o SHALL be mutually exclusive.

Reset
REQ-041 During reset and the cycle after it: FSM=IDLE, all outputs 0, counters cleared, any readout in flight aborted.
REQ-042 Reset SHALL NOT initialise memory contents; write ports remain functional from the first cycle after reset.

Verification
REQ-043 Bench parameters: pages=4, page_size=8, ratio=2, width=16, wports=2.
REQ-044 Write line 0 = 0x2222_1111; start size=2; page 0 -> dout 0x1111 then 0x2222, last on the second word, busy 0 after.
REQ-045 Start size=10; pages 2 then 1 -> 8 words from lines 8-11, page request, 2 words from line 4, last on the 10th word.
REQ-046 Size=3 -> last on lane 0 of line 1; lane 1 is not output; next page is not requested.
REQ-047 Both ports write addr 5, port0=0xAAAA_AAAA, port1=0xBBBB_BBBB -> readback gives 0xAAAA.
REQ-048 dout_ready_i low 3 cycles mid-stream -> dout_o held; size=0 start and start while busy -> rd_error_o single pulse.
REQ-049 rst_i asserted mid-STREAM -> next cycle dout_valid_o=0, rd_busy_o=0, rd_page_ready_o=0.
